nco_freq_estimator: RTL

- Inverse of the team's square-wave NCO: measures the frequency of an external 1-bit square wave and reports the equivalent NCO phase increment.
- Feeding the result to the NCO reproduces the input frequency.
- Sits on the receive/calibration side of the SDR chain, where it locks NCO tuning to a measured reference or carrier.
- Method: count rising edges over a fixed gate of 2^GATE_LOG2 clocks; phase increment = edge count << (REGISTER_WIDTH − GATE_LOG2). No divider.

---
 rtl/nco_freq_estimator_if.sv | 22 ++
 rtl/nco_freq_estimator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/nco_freq_estimator_if.sv
// rtl/nco_freq_estimator_if.sv - control, input and result signals of the NCO frequency estimator
interface nco_freq_estimator_if #(
  parameter int REGISTER_WIDTH = 64,
  parameter int GATE_LOG2      = 20
);
  logic                      enable;
  logic                      sig_in;
  logic [REGISTER_WIDTH-1:0] phase_increment_est;
  logic                      est_valid;
  logic [GATE_LOG2-1:0]      edge_count;
  logic                      gate_active;

  modport master (
    output enable, sig_in,
    input  phase_increment_est, est_valid, edge_count, gate_active
  );

  modport slave (
    input  enable, sig_in,
    output phase_increment_est, est_valid, edge_count, gate_active
  );
endinterface

// File: rtl/nco_freq_estimator.sv
// rtl/nco_freq_estimator.sv - gated rising-edge counter reporting the NCO phase increment of sig_in
// Optional NCO_EST_AVG_EN: report the mean of the last 4 gates at 4x finer LSB.
module nco_freq_estimator #(
  parameter int REGISTER_WIDTH = 64,
  parameter int GATE_LOG2      = 20,
  parameter int SYNC_STAGES    = 2
) (
  input logic                clk,
  input logic                rst,
  nco_freq_estimator_if.slave est
);
  localparam int SHIFT = REGISTER_WIDTH - GATE_LOG2;
  localparam logic [GATE_LOG2-1:0] GATE_LAST = {GATE_LOG2{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_LATCH} state_t;

  state_t                    state_q, state_d;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      prev_q;
  logic                      rise;
  logic [GATE_LOG2-1:0]      gate_cnt_q, gate_cnt_d;
  logic [GATE_LOG2-1:0]      acc_q, acc_d;
  logic [GATE_LOG2-1:0]      edge_count_q, edge_count_d;
  logic [REGISTER_WIDTH-1:0] est_q, est_d;
  logic                      valid_q, valid_d;

`ifdef NCO_EST_AVG_EN
  logic [3:0][GATE_LOG2-1:0] hist_q, hist_d;
  logic [GATE_LOG2+1:0]      sum_q, sum_d;
  logic [2:0]                fill_q, fill_d;
`endif

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    est_d        = est_q;
    valid_d      = 1'b0;
`ifdef NCO_EST_AVG_EN
    hist_d       = hist_q;
    sum_d        = sum_q;
    fill_d       = fill_q;
`endif
    if (!est.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        // The arming edge only aligns the gate to signal phase; it is not counted.
        S_ARM: begin
          if (rise) begin
            state_d    = S_GATE;
            gate_cnt_d = '0;
            acc_d      = '0;
          end
        end
        S_GATE: begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          acc_d      = acc_q + {{(GATE_LOG2-1){1'b0}}, rise};
          if (gate_cnt_q == GATE_LAST) state_d = S_LATCH;
        end
        S_LATCH: begin
          edge_count_d = acc_q;
`ifdef NCO_EST_AVG_EN
          sum_d  = sum_q + {2'b00, acc_q} - {2'b00, hist_q[3]};
          hist_d = {hist_q[2:0], acc_q};
          fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
          if (fill_q >= 3'd3) begin
            est_d   = REGISTER_WIDTH'(sum_d) << (SHIFT - 2);
            valid_d = 1'b1;
          end
`else
          est_d   = REGISTER_WIDTH'(acc_q) << SHIFT;
          valid_d = 1'b1;
`endif
          state_d    = S_GATE;
          gate_cnt_d = '0;
          acc_d      = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef NCO_EST_AVG_EN
    if (state_q == S_IDLE || state_q == S_ARM) begin
      hist_d = '0;
      sum_d  = '0;
      fill_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      edge_count_q <= '0;
      est_q        <= '0;
      valid_q      <= 1'b0;
`ifdef NCO_EST_AVG_EN
      hist_q       <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], est.sig_in};
      prev_q       <= sync_q[SYNC_STAGES-1];
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
      est_q        <= est_d;
      valid_q      <= valid_d;
`ifdef NCO_EST_AVG_EN
      hist_q       <= hist_d;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
`endif
    end
  end

  assign est.phase_increment_est = est_q;
  assign est.est_valid           = valid_q;
  assign est.edge_count          = edge_count_q;
  assign est.gate_active         = (state_q == S_GATE);
endmodule
